// File: rtl/adder_checker.sv
// Response checker for adder blocks: samples operand/result vectors, compares them
// against a golden sum one cycle later, counts mismatches and keeps the first failure.
module adder_checker #(
  parameter int WIDTH   = 1,
  parameter int NUM_VEC = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             ci_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             co_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fail_vld_o,
  output logic [WIDTH-1:0] fail_a_o,
  output logic [WIDTH-1:0] fail_b_o,
  output logic             fail_ci_o,
  output logic [WIDTH-1:0] fail_sum_o,
  output logic             fail_co_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VEC - 1);

  state_e state_q, state_d;

  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_ci_q, s1_ci_d;
  logic [WIDTH-1:0] s1_sum_q, s1_sum_d;
  logic             s1_co_q, s1_co_d;

  logic             fail_vld_q, fail_vld_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic             fail_ci_q, fail_ci_d;
  logic [WIDTH-1:0] fail_sum_q, fail_sum_d;
  logic             fail_co_q, fail_co_d;

  logic             start_run;
  logic             accept;
  logic [WIDTH:0]   golden;
  logic             mismatch;

  // NOTE: every signal assigned in an always_comb gets a default on entry so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_RUN;
          start_run = 1'b1;
        end
      end
      S_RUN: begin
        if (valid_i) begin
          accept = 1'b1;
          if (vec_cnt_q == LAST_VEC) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Golden result carries one extra bit so the expected carry-out falls out of the add.
  assign golden   = {1'b0, s1_a_q} + {1'b0, s1_b_q} + {{WIDTH{1'b0}}, s1_ci_q};
  assign mismatch = s1_vld_q && ({s1_co_q, s1_sum_q} != golden);

  always_comb begin
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    s1_vld_d   = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_ci_d    = s1_ci_q;
    s1_sum_d   = s1_sum_q;
    s1_co_d    = s1_co_q;
    fail_vld_d = fail_vld_q;
    fail_a_d   = fail_a_q;
    fail_b_d   = fail_b_q;
    fail_ci_d  = fail_ci_q;
    fail_sum_d = fail_sum_q;
    fail_co_d  = fail_co_q;

    if (accept) begin
      s1_a_d    = op_a_i;
      s1_b_d    = op_b_i;
      s1_ci_d   = ci_i;
      s1_sum_d  = sum_i;
      s1_co_d   = co_i;
      vec_cnt_d = vec_cnt_q + 1'b1;
    end

    if (mismatch) begin
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      if (!fail_vld_q) begin
        fail_vld_d = 1'b1;
        fail_a_d   = s1_a_q;
        fail_b_d   = s1_b_q;
        fail_ci_d  = s1_ci_q;
        fail_sum_d = s1_sum_q;
        fail_co_d  = s1_co_q;
      end
    end

    // A new run starts from a clean record; no compare is in flight in IDLE or DONE.
    if (start_run) begin
      vec_cnt_d  = '0;
      err_cnt_d  = '0;
      fail_vld_d = 1'b0;
      fail_a_d   = '0;
      fail_b_d   = '0;
      fail_ci_d  = 1'b0;
      fail_sum_d = '0;
      fail_co_d  = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values of the others, matching the hardware it describes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      s1_vld_q   <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_ci_q    <= 1'b0;
      s1_sum_q   <= '0;
      s1_co_q    <= 1'b0;
      fail_vld_q <= 1'b0;
      fail_a_q   <= '0;
      fail_b_q   <= '0;
      fail_ci_q  <= 1'b0;
      fail_sum_q <= '0;
      fail_co_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      s1_vld_q   <= s1_vld_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_ci_q    <= s1_ci_d;
      s1_sum_q   <= s1_sum_d;
      s1_co_q    <= s1_co_d;
      fail_vld_q <= fail_vld_d;
      fail_a_q   <= fail_a_d;
      fail_b_q   <= fail_b_d;
      fail_ci_q  <= fail_ci_d;
      fail_sum_q <= fail_sum_d;
      fail_co_q  <= fail_co_d;
    end
  end

  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign pass_o     = done_o && (err_cnt_q == '0);
  assign err_cnt_o  = err_cnt_q;
  assign fail_vld_o = fail_vld_q;
  assign fail_a_o   = fail_a_q;
  assign fail_b_o   = fail_b_q;
  assign fail_ci_o  = fail_ci_q;
  assign fail_sum_o = fail_sum_q;
  assign fail_co_o  = fail_co_q;

endmodule

// File: tb/tb_adder_checker.sv
// Bench for adder_checker: three instances (half adder, narrow counter, 4-bit adder)
// checked every cycle against a vector-level model, plus directed literal checks.
module tb_adder_checker;

  localparam int NDUT = 3;
  localparam int P_W [NDUT] = '{1, 1, 4};
  localparam int P_N [NDUT] = '{4, 3, 4};
  localparam int P_C [NDUT] = '{8, 2, 8};

  localparam int PH_IDLE  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_DRAIN = 2;
  localparam int PH_DONE  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut 0: WIDTH=1 NUM_VEC=4 CNT_W=8
  logic start0 = 0, valid0 = 0, ci0 = 0, co0 = 0;
  logic [0:0] a0 = '0, b0 = '0, sum0 = '0;
  logic busy0, done0, pass0, fvld0, fci0, fco0;
  logic [7:0] err0;
  logic [0:0] fa0, fb0, fs0;
  // dut 1: WIDTH=1 NUM_VEC=3 CNT_W=2
  logic start1 = 0, valid1 = 0, ci1 = 0, co1 = 0;
  logic [0:0] a1 = '0, b1 = '0, sum1 = '0;
  logic busy1, done1, pass1, fvld1, fci1, fco1;
  logic [1:0] err1;
  logic [0:0] fa1, fb1, fs1;
  // dut 2: WIDTH=4 NUM_VEC=4 CNT_W=8
  logic start2 = 0, valid2 = 0, ci2 = 0, co2 = 0;
  logic [3:0] a2 = '0, b2 = '0, sum2 = '0;
  logic busy2, done2, pass2, fvld2, fci2, fco2;
  logic [7:0] err2;
  logic [3:0] fa2, fb2, fs2;

  adder_checker #(.WIDTH(1), .NUM_VEC(4), .CNT_W(8)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .valid_i(valid0),
    .op_a_i(a0), .op_b_i(b0), .ci_i(ci0), .sum_i(sum0), .co_i(co0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_cnt_o(err0),
    .fail_vld_o(fvld0), .fail_a_o(fa0), .fail_b_o(fb0), .fail_ci_o(fci0),
    .fail_sum_o(fs0), .fail_co_o(fco0)
  );

  adder_checker #(.WIDTH(1), .NUM_VEC(3), .CNT_W(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .valid_i(valid1),
    .op_a_i(a1), .op_b_i(b1), .ci_i(ci1), .sum_i(sum1), .co_i(co1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
    .fail_vld_o(fvld1), .fail_a_o(fa1), .fail_b_o(fb1), .fail_ci_o(fci1),
    .fail_sum_o(fs1), .fail_co_o(fco1)
  );

  adder_checker #(.WIDTH(4), .NUM_VEC(4), .CNT_W(8)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .valid_i(valid2),
    .op_a_i(a2), .op_b_i(b2), .ci_i(ci2), .sum_i(sum2), .co_i(co2),
    .busy_o(busy2), .done_o(done2), .pass_o(pass2), .err_cnt_o(err2),
    .fail_vld_o(fvld2), .fail_a_o(fa2), .fail_b_o(fb2), .fail_ci_o(fci2),
    .fail_sum_o(fs2), .fail_co_o(fco2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one record per instance ----------------
  int m_phase [NDUT];
  int m_cnt   [NDUT];
  int m_err   [NDUT];
  bit m_fvld  [NDUT];
  int m_fa [NDUT], m_fb [NDUT], m_fs [NDUT];
  bit m_fci [NDUT], m_fco [NDUT];
  // vector accepted last edge whose verdict becomes visible on the next edge
  bit p_vld [NDUT], p_bad [NDUT], p_ci [NDUT], p_co [NDUT];
  int p_a [NDUT], p_b [NDUT], p_s [NDUT];

  task automatic clear_record(input int d);
    m_err[d] = 0; m_fvld[d] = 0; m_fa[d] = 0; m_fb[d] = 0;
    m_fs[d] = 0; m_fci[d] = 0; m_fco[d] = 0; m_cnt[d] = 0;
  endtask

  always @(posedge clk or posedge rst) begin
    bit st, vl, ci, co;
    int a, b, s;
    if (rst) begin
      for (int d = 0; d < NDUT; d++) begin
        clear_record(d);
        m_phase[d] = PH_IDLE;
        p_vld[d] = 0;
      end
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        case (d)
          0: begin st = start0; vl = valid0; a = int'(a0); b = int'(b0); ci = ci0; s = int'(sum0); co = co0; end
          1: begin st = start1; vl = valid1; a = int'(a1); b = int'(b1); ci = ci1; s = int'(sum1); co = co1; end
          default: begin st = start2; vl = valid2; a = int'(a2); b = int'(b2); ci = ci2; s = int'(sum2); co = co2; end
        endcase
        if (p_vld[d]) begin
          if (p_bad[d]) begin
            if (m_err[d] < (1 << P_C[d]) - 1) m_err[d]++;
            if (!m_fvld[d]) begin
              m_fvld[d] = 1; m_fa[d] = p_a[d]; m_fb[d] = p_b[d];
              m_fci[d] = p_ci[d]; m_fs[d] = p_s[d]; m_fco[d] = p_co[d];
            end
          end
          p_vld[d] = 0;
        end
        case (m_phase[d])
          PH_IDLE, PH_DONE: if (st) begin
            clear_record(d);
            m_phase[d] = PH_RUN;
          end
          PH_RUN: if (vl) begin
            p_vld[d] = 1;
            p_bad[d] = (a + b + int'(ci)) != (int'(co) * (1 << P_W[d]) + s);
            p_a[d] = a; p_b[d] = b; p_ci[d] = ci; p_s[d] = s; p_co[d] = co;
            m_cnt[d]++;
            if (m_cnt[d] == P_N[d]) m_phase[d] = PH_DRAIN;
          end
          PH_DRAIN: m_phase[d] = PH_DONE;
          default: m_phase[d] = PH_IDLE;
        endcase
      end
    end
  end

  task automatic cmp(input int d, input logic busy, input logic done, input logic pass,
                     input int err, input logic fvld, input int fa, input int fb,
                     input logic fci, input int fs, input logic fco);
    string p;
    bit mdone;
    p = $sformatf("d%0d_", d);
    mdone = (m_phase[d] == PH_DONE);
    check({p, "busy"}, busy, m_phase[d] == PH_RUN || m_phase[d] == PH_DRAIN);
    check({p, "done"}, done, mdone);
    check({p, "pass"}, pass, mdone && m_err[d] == 0);
    check({p, "err_cnt"}, err, m_err[d]);
    check({p, "fail_vld"}, fvld, m_fvld[d]);
    check({p, "fail_a"}, fa, m_fa[d]);
    check({p, "fail_b"}, fb, m_fb[d]);
    check({p, "fail_ci"}, fci, m_fci[d]);
    check({p, "fail_sum"}, fs, m_fs[d]);
    check({p, "fail_co"}, fco, m_fco[d]);
  endtask

  always @(negedge clk) begin
    cmp(0, busy0, done0, pass0, int'(err0), fvld0, int'(fa0), int'(fb0), fci0, int'(fs0), fco0);
    cmp(1, busy1, done1, pass1, int'(err1), fvld1, int'(fa1), int'(fb1), fci1, int'(fs1), fco1);
    cmp(2, busy2, done2, pass2, int'(err2), fvld2, int'(fa2), int'(fb2), fci2, int'(fs2), fco2);
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input int d, input bit st, input bit vl, input int a, input int b,
                       input bit ci, input int s, input bit co);
    case (d)
      0: begin start0 = st; valid0 = vl; a0 = a[0:0]; b0 = b[0:0]; ci0 = ci; sum0 = s[0:0]; co0 = co; end
      1: begin start1 = st; valid1 = vl; a1 = a[0:0]; b1 = b[0:0]; ci1 = ci; sum1 = s[0:0]; co1 = co; end
      default: begin start2 = st; valid2 = vl; a2 = a[3:0]; b2 = b[3:0]; ci2 = ci; sum2 = s[3:0]; co2 = co; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d);
    drive(d, 1, 0, 0, 0, 0, 0, 0);
    tick();
    drive(d, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(input int d, input int a, input int b, input bit ci,
                      input int s, input bit co, input int gap);
    drive(d, 0, 1, a, b, ci, s, co);
    tick();
    drive(d, 0, 0, 0, 0, 0, 0, 0);
    repeat (gap) tick();
  endtask

  task automatic send_ok(input int d, input int a, input int b, input bit ci, input int gap);
    int t;
    t = a + b + int'(ci);
    send(d, a, b, ci, t % (1 << P_W[d]), bit'(t >> P_W[d]), gap);
  endtask

  function automatic logic done_of(input int d);
    case (d)
      0: return done0;
      1: return done1;
      default: return done2;
    endcase
  endfunction

  task automatic wait_done(input int d, input int budget);
    int n;
    n = 0;
    while (!done_of(d) && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("d%0d_done_within_budget", d), done_of(d), 1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_err_cnt", err0, 0);
    #20 rst = 1'b0;
    tick();

    // exhaustive correct half adder: DONE exactly 5 edges after START
    pulse_start(0);
    send_ok(0, 0, 0, 0, 0);
    send_ok(0, 0, 1, 0, 0);
    send_ok(0, 1, 0, 0, 0);
    send_ok(0, 1, 1, 0, 0);
    check("ha_done_after_4", done0, 0);
    check("ha_busy_drain", busy0, 1);
    tick();
    check("ha_done_after_5", done0, 1);
    check("ha_pass", pass0, 1);
    check("ha_err_cnt", err0, 0);
    check("ha_fail_vld", fvld0, 0);
    check("model_ha_err", m_err[0], 0);

    // single injected fault on (1,1): SUM=1 CO=1
    pulse_start(0);
    send_ok(0, 0, 0, 0, 0);
    send_ok(0, 0, 1, 0, 0);
    send_ok(0, 1, 0, 0, 0);
    send(0, 1, 1, 0, 1, 1, 0);
    tick();
    check("flt_err_cnt", err0, 1);
    check("flt_fail_vld", fvld0, 1);
    check("flt_fail_a", fa0, 1);
    check("flt_fail_b", fb0, 1);
    check("flt_fail_sum", fs0, 1);
    check("flt_fail_co", fco0, 1);
    check("flt_pass", pass0, 0);
    check("model_flt_err", m_err[0], 1);
    check("model_flt_fail_a", m_fa[0], 1);

    // every vector wrong on the 2-bit counter; first failure is held
    pulse_start(1);
    send(1, 0, 1, 0, 0, 0, 0);
    send(1, 1, 1, 0, 1, 1, 0);
    send(1, 0, 0, 0, 1, 0, 0);
    wait_done(1, 4);
    check("sat_err_cnt", err1, 3);
    check("sat_fail_a", fa1, 0);
    check("sat_fail_b", fb1, 1);
    check("sat_fail_sum", fs1, 0);
    check("sat_fail_co", fco1, 0);
    check("sat_pass", pass1, 0);

    // 4-bit full adder with gaps; a wrong vector before START must be ignored
    send(2, 15, 15, 1, 0, 0, 1);
    pulse_start(2);
    for (int i = 0; i < 4; i++) send(2, 15, 15, 1, 15, 1, 2);
    wait_done(2, 4);
    check("fa_pass", pass2, 1);
    check("fa_err_cnt", err2, 0);

    // asynchronous reset between edges after 2 of 4 vectors
    pulse_start(0);
    send(0, 1, 1, 0, 1, 0, 0);
    send_ok(0, 1, 0, 0, 0);
    check("pre_rst_err_cnt", err0, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_done", done0, 0);
    check("mid_rst_err_cnt", err0, 0);
    check("mid_rst_fail_vld", fvld0, 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_start(0);
    for (int i = 0; i < 4; i++) send_ok(0, i / 2, i % 2, 0, 0);
    wait_done(0, 4);
    check("post_rst_pass", pass0, 1);

    // START ignored while busy (also with a vector), then START in DONE reruns
    pulse_start(0);
    send(0, 0, 1, 0, 0, 0, 0);
    pulse_start(0);
    drive(0, 1, 1, 1, 1, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("ign_busy", busy0, 1);
    send_ok(0, 1, 0, 0, 0);
    send_ok(0, 0, 0, 0, 0);
    wait_done(0, 4);
    check("ign_err_cnt", err0, 1);
    check("ign_fail_b", fb0, 1);
    pulse_start(0);
    check("rerun_busy", busy0, 1);
    check("rerun_err_cnt", err0, 0);
    check("rerun_fail_vld", fvld0, 0);
    for (int i = 0; i < 4; i++) send_ok(0, 1, 1, 1, 0);
    wait_done(0, 4);
    check("rerun_pass", pass0, 1);

    // randomized runs on all instances, checked cycle by cycle by the model
    for (int r = 0; r < 24; r++) begin
      int d, n, maxv, a, b, s;
      bit ci, co;
      d = $urandom_range(0, NDUT - 1);
      maxv = (1 << P_W[d]) - 1;
      pulse_start(d);
      n = 0;
      while (n < P_N[d]) begin
        a = $urandom_range(0, maxv);
        b = $urandom_range(0, maxv);
        ci = bit'($urandom_range(0, 1));
        s = (a + b + int'(ci)) % (1 << P_W[d]);
        co = bit'((a + b + int'(ci)) >> P_W[d]);
        if ($urandom_range(0, 3) == 0) begin
          s = $urandom_range(0, maxv);
          co = bit'($urandom_range(0, 1));
        end
        drive(d, $urandom_range(0, 5) == 0, 1, a, b, ci, s, co);
        tick();
        drive(d, 0, 0, 0, 0, 0, 0, 0);
        n++;
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_done(d, 4);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_checker.md
# adder_checker

Synthesizable response checker for the adder blocks: the consuming end of the operand/result interface that the adder benches drive. Each vector is sampled as operands A, B and carry-in, plus the adder's SUM and CO. The checker compares the result against an internal golden sum and counts mismatches over a fixed-length run. It captures the first failing vector and reports PASS/FAIL, so adder testing can run on hardware as well as in simulation.

## Interface
- WIDTH, 1, operand and sum width in bits (1 = half/full adder)
- NUM_VEC, 4, vectors per run; must be >= 1 and < 2**CNT_W
- CNT_W, 8, width of the vector and error counters
- CLK  in  1  rising-edge clock; the only clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  begin a run; honoured only in IDLE or DONE
- VALID  in  1  the vector on the inputs below is present this cycle
- OP_A  in  WIDTH  operand A
- OP_B  in  WIDTH  operand B
- CI  in  1  carry-in; tie 0 when checking a half adder
- SUM  in  WIDTH  adder sum under test
- CO  in  1  adder carry-out under test
- BUSY  out  1  high in RUN and DRAIN
- DONE  out  1  high in DONE
- PASS  out  1  DONE and ERR_CNT == 0
- ERR_CNT  out  CNT_W  mismatch count; saturates at all-ones
- FAIL_VLD  out  1  a first-failure record is held
- FAIL_A, FAIL_B  out  WIDTH  operands of the first failing vector
- FAIL_CI  out  1  carry-in of the first failing vector
- FAIL_SUM  out  WIDTH  SUM observed on the first failing vector
- FAIL_CO  out  1  CO observed on the first failing vector

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- **Reset:** RST forces IDLE. Every output and internal register goes to 0.
- **IDLE → RUN on START:**
  - Clears ERR_CNT, the vector count, FAIL_VLD and all FAIL_* fields.
- **DONE → RUN on START:** same clears as IDLE → RUN.
- **START elsewhere:** ignored in RUN and in DRAIN.
- **Vector acceptance (RUN only):**
  - A vector is accepted on any RUN edge where VALID = 1.
  - VALID outside RUN is ignored.
  - Gaps between VALID pulses are allowed; there is no backpressure.
- **Stage 1 (accept edge):**
  - Register OP_A, OP_B, CI, SUM and CO.
  - Increment the vector count.
- **Stage 2 (next edge):**
  - Golden result = OP_A + OP_B + CI, computed at WIDTH+1 bits; bit WIDTH is the expected CO.
  - Mismatch = the registered {CO, SUM} differs from the golden result.
  - On a mismatch, ERR_CNT increments unless it is already all-ones.
  - On a mismatch with FAIL_VLD = 0, load the FAIL_* fields from the stage-1 registers and set FAIL_VLD.
  - Later mismatches leave the FAIL_* fields unchanged.
- **RUN → DRAIN:** on the edge that accepts vector number NUM_VEC.
- **DRAIN → DONE:** unconditional, one cycle after entering DRAIN. This edge retires the last stage-2 compare.
- **DONE:** holds all results until START or RST.
- X/Z on the inputs is not handled; callers drive known values.

## Timing
- Vector accepted at edge E: its mismatch shows on ERR_CNT and FAIL_* after edge E+1.
- Last vector accepted at edge E:
  - BUSY stays high through DRAIN.
  - DONE and PASS become valid after edge E+1.
  - ERR_CNT is final when DONE rises.
- Minimum run is NUM_VEC+1 cycles after the START edge, with VALID held high.
- START → BUSY: 1 edge.
- Asynchronous RST mid-run: all outputs go to 0 immediately, with no clock. The in-flight compare is discarded.
- Back-to-back runs: START in DONE re-enters RUN on that edge, and the results are cleared on the same edge.

## Test plan
- **Exhaustive correct half adder:**
  - Stimulus: WIDTH=1, NUM_VEC=4, CI=0, VALID held high, vectors (0,0), (0,1), (1,0), (1,1) with correct SUM/CO.
  - Required response: DONE after 5 cycles, PASS=1, ERR_CNT=0, FAIL_VLD=0.
- **Single injected fault:**
  - Stimulus: same run, but vector (1,1) is driven with SUM=1, CO=1.
  - Required response: ERR_CNT=1, FAIL_VLD=1, FAIL_A=1, FAIL_B=1, FAIL_SUM=1, FAIL_CO=1, PASS=0.
- **First-failure hold and saturation:**
  - Stimulus: CNT_W=2, NUM_VEC=3, all three vectors wrong, first vector (0,1) with SUM=0.
  - Required response: ERR_CNT=3; FAIL_* still hold (0,1,SUM=0,CO=0).
- **Full-adder width and VALID gaps:**
  - Stimulus: WIDTH=4, CI=1, A=15, B=15, SUM=15, CO=1; VALID pulsed every 3rd cycle.
  - Required response: no error, PASS=1. Vectors sent before START are not counted.
- **Reset mid-run:**
  - Stimulus: assert RST between edges after 2 of 4 vectors.
  - Required response: BUSY, DONE and ERR_CNT are 0 immediately. A fresh START then runs 4 vectors normally.
- **START ignored while busy, then rerun:**
  - Stimulus: pulse START in RUN; later pulse START in DONE.
  - Required response: the run in progress is unaffected. The START in DONE clears ERR_CNT and FAIL_VLD and returns to RUN on the same edge.
